// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared Mandelbrot pipeline constants and sequencer state encoding
package mandel_pkg;

  localparam int FP_W     = 27;
  localparam int FRAC_W   = 23;
  localparam int ITER_MAX = 1000;
  localparam int ITER_W   = $clog2(ITER_MAX) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE
  } seq_state_e;

endpackage

// File: rtl/mandel_coord_stepper.sv
// rtl/mandel_coord_stepper.sv - incremental raster walker producing c, pixel address and end-of-row/frame flags
module mandel_coord_stepper
  import mandel_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv_col,
  input  logic              adv_row,
  input  logic [FP_W-1:0]   x_start,
  input  logic [FP_W-1:0]   y_start,
  input  logic [FP_W-1:0]   step,
  output logic [FP_W-1:0]   cur_r,
  output logic [FP_W-1:0]   cur_i,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pixel
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [FP_W-1:0]   x_start_q, x_start_d;
  logic [FP_W-1:0]   step_q, step_d;
  logic [FP_W-1:0]   cur_r_q, cur_r_d;
  logic [FP_W-1:0]   cur_i_q, cur_i_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Two's complement add/sub wraps modulo 2^FP_W by construction.
  always_comb begin
    x_start_d = x_start_q;
    step_d    = step_q;
    cur_r_d   = cur_r_q;
    cur_i_d   = cur_i_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    if (load) begin
      x_start_d = x_start;
      step_d    = step;
      cur_r_d   = x_start;
      cur_i_d   = y_start;
      x_d       = '0;
      y_d       = '0;
      addr_d    = '0;
    end else if (adv_row) begin
      x_d     = '0;
      y_d     = y_q + Y_W'(1);
      cur_r_d = x_start_q;
      cur_i_d = cur_i_q - step_q;
      addr_d  = addr_q + ADDR_W'(1);
    end else if (adv_col) begin
      x_d     = x_q + X_W'(1);
      cur_r_d = cur_r_q + step_q;
      addr_d  = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_start_q <= '0;
      step_q    <= '0;
      cur_r_q   <= '0;
      cur_i_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
    end else begin
      x_start_q <= x_start_d;
      step_q    <= step_d;
      cur_r_q   <= cur_r_d;
      cur_i_q   <= cur_i_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
    end
  end

  assign cur_r      = cur_r_q;
  assign cur_i      = cur_i_q;
  assign addr       = addr_q;
  assign last_col   = (x_q == X_W'(H_RES - 1));
  assign last_pixel = last_col && (y_q == Y_W'(V_RES - 1));

endmodule

// File: rtl/mandel_pixel_sequencer.sv
// rtl/mandel_pixel_sequencer.sv - one-pixel-in-flight frame sequencer between iterator and frame-buffer writer
module mandel_pixel_sequencer
  import mandel_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ITER_MAX = mandel_pkg::ITER_MAX,
  parameter int ITER_W   = $clog2(ITER_MAX) + 1,
  parameter int ADDR_W   = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FP_W-1:0]   x_start,
  input  logic [FP_W-1:0]   y_start,
  input  logic [FP_W-1:0]   step,
  output logic              busy,
  output logic              frame_done,
  output logic              it_in_val,
  input  logic              it_in_rdy,
  output logic [FP_W-1:0]   it_c_r,
  output logic [FP_W-1:0]   it_c_i,
  input  logic              it_out_val,
  output logic              it_out_rdy,
  input  logic [ITER_W-1:0] it_iter_count,
  output logic              px_val,
  input  logic              px_rdy,
  output logic [ADDR_W-1:0] px_addr,
  output logic [ITER_W-1:0] px_iter
);

  seq_state_e        state_q, state_d;
  logic [ITER_W-1:0] px_iter_q, px_iter_d;
  logic              load, adv_col, adv_row;
  logic              last_col, last_pixel;

  mandel_coord_stepper #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_stepper (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .adv_col   (adv_col),
    .adv_row   (adv_row),
    .x_start   (x_start),
    .y_start   (y_start),
    .step      (step),
    .cur_r     (it_c_r),
    .cur_i     (it_c_i),
    .addr      (px_addr),
    .last_col  (last_col),
    .last_pixel(last_pixel)
  );

  always_comb begin
    state_d   = state_q;
    px_iter_d = px_iter_q;
    load      = 1'b0;
    adv_col   = 1'b0;
    adv_row   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (it_in_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (it_out_val) begin
          px_iter_d = it_iter_count;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (px_rdy) begin
          if (last_pixel) begin
            state_d = ST_IDLE;
          end else begin
            adv_row = last_col;
            adv_col = !last_col;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      px_iter_q <= '0;
    end else begin
      state_q   <= state_d;
      px_iter_q <= px_iter_d;
    end
  end

  // Handshake outputs are pure state decodes; frame_done marks the final write handshake itself.
  assign busy       = (state_q != ST_IDLE);
  assign it_in_val  = (state_q == ST_ISSUE);
  assign it_out_rdy = (state_q == ST_WAIT);
  assign px_val     = (state_q == ST_WRITE);
  assign px_iter    = px_iter_q;
  assign frame_done = (state_q == ST_WRITE) && px_rdy && last_pixel;

endmodule

// File: doc/mandel_pixel_sequencer.md
# mandel_pixel_sequencer

Frame-level sequencer that walks every pixel of a frame in raster order. For each pixel it issues the complex coordinate c to the Mandelbrot iterator and collects the resulting iteration count. It then emits a pixel write (address, count) to the frame-buffer/colour stage. It sits directly upstream of the iterator (drives its input handshake) and terminates the iterator's output handshake. Exactly one pixel is in flight at a time.

## Interface
- H_RES, 640, pixels per row
- V_RES, 480, rows per frame
- ITER_MAX, 1000, iterator iteration limit; ITER_W = $clog2(ITER_MAX)+1
- ADDR_W, $clog2(H_RES*V_RES), pixel address width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- x_start  in  27  signed Q4.23 c_r of the left column; latched on accepted start
- y_start  in  27  signed Q4.23 c_i of the top row; latched on accepted start
- step  in  27  signed Q4.23 per-pixel increment; latched on accepted start
- busy  out  1  high from accepted start until the final pixel write completes
- frame_done  out  1  one-cycle pulse on final pixel write handshake
- it_in_val  out  1  coordinate valid to iterator
- it_in_rdy  in  1  iterator accepts coordinate
- it_c_r, it_c_i  out  27  coordinate to iterator, Q4.23
- it_out_val  in  1  iterator result valid
- it_out_rdy  out  1  sequencer accepts result
- it_iter_count  in  ITER_W  iteration count from iterator
- px_val  out  1  pixel write valid
- px_rdy  in  1  downstream accepts pixel write
- px_addr  out  ADDR_W  y*H_RES + x
- px_iter  out  ITER_W  captured iteration count

## Operation
- States: IDLE, ISSUE, WAIT, WRITE. All handshake outputs are decoded from state (Moore): it_in_val=ISSUE, it_out_rdy=WAIT, px_val=WRITE, busy=not IDLE.
- IDLE + start: latch x_start, y_start and step. Load cur_r=x_start, cur_i=y_start, x=0, y=0, addr=0. Go to ISSUE.
- ISSUE: drive it_c_r=cur_r and it_c_i=cur_i. On it_in_rdy, go to WAIT.
- WAIT: on it_out_val, capture it_iter_count into px_iter and go to WRITE.
- WRITE: drive px_addr=addr and px_iter. On px_rdy:
  - If x==H_RES-1 and y==V_RES-1: pulse frame_done and go to IDLE.
  - Else if x==H_RES-1: x=0, y+=1, cur_r=x_start, cur_i-=step, addr+=1, go to ISSUE.
  - Else: x+=1, cur_r+=step, addr+=1, go to ISSUE.
- Coordinate arithmetic is 27-bit two's complement and wraps modulo 2^27 with no saturation. Coordinates are generated incrementally; no multiplier is used.
- start outside IDLE is ignored. New x_start, y_start and step values have no effect mid-frame.
- Reset mid-frame: the next state is IDLE, and counters and outputs take their reset values. The iterator shares reset, so no stale result is expected.

## Timing
- Reset values: busy 0, frame_done 0, it_in_val 0, it_out_rdy 0, px_val 0, it_c_r 0, it_c_i 0, px_addr 0, px_iter 0.
- Accepted start: it_in_val rises on the next cycle.
- Each state consumes at least one cycle per pixel: minimum 3 cycles per pixel plus iterator latency.
- Valid/data held stable while the corresponding ready is low. it_c_r and it_c_i are registered and change only in the WRITE→ISSUE transition.
- frame_done is asserted in the same cycle as the final px_val && px_rdy. busy falls on the next cycle.
- start in the cycle after frame_done (IDLE) is accepted normally.

## Structure
- Shared package mandel_pkg: FP_W=27, FRAC_W=23, ITER_MAX, ITER_W, and the sequencer state enum. The iterator and colour stage import the same constants.
- One natural sub-module: mandel_coord_stepper. It holds cur_r, cur_i, x, y and addr, with load, advance-column and advance-row controls plus a last_col/last_pixel flag. The FSM stays in the top module.

## Test plan
- Small frame (H_RES=4, V_RES=2), x_start=27'h7000000 (-2.0), y_start=27'h0800000 (1.0), step=27'h0400000 (0.5), iterator model returns count=x+y → issued c_r -2.0,-1.5,-1.0,-0.5 per row, c_i 1.0 then 0.5; px_addr 0..7; frame_done exactly once on the 8th write.
- it_in_rdy low for 5 cycles in ISSUE → it_in_val stays 1, it_c_r and it_c_i unchanged, no state advance.
- px_rdy low for 4 cycles → px_val, px_addr and px_iter held; no new it_in_val until the write completes.
- start pulsed mid-frame with different x_start → ignored; the frame completes with the original coordinates. start on the cycle after frame_done → new frame begins at addr 0.
- reset asserted while in WAIT at addr 5 → next cycle all outputs at reset values, busy 0. A subsequent start restarts at addr 0.
- Wrap: x_start=27'h3FFFFFF, step=27'h0000001 → the second pixel's c_r is 27'h4000000 (most negative); no saturation.
